i2c_seq: RTL and testbench

- Command sequencer directly upstream of the I2C master controller (i2c_mc).
- On request, walks a table of 16-bit command words (e.g. codec register init) and hands each word to i2c_mc via data/start.
- Waits for i2c_mc done/error, retries failed transfers, inserts an inter-command gap, and reports overall completion or failure to the system.

---
 rtl/i2c_seq_if.sv | 22 ++
 rtl/i2c_seq.sv | 153 +++++++++++++++
 tb/tb_i2c_seq.sv | 354 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_seq_if.sv
// Sequencer-side link: command-table lookup plus the data/start/done/error
// handshake with the I2C master controller.
interface i2c_seq_if #(
   parameter int unsigned ADDR_W = 4
);
   logic [ADDR_W-1:0] cmd_addr;
   logic [15:0]       cmd_data;
   logic [15:0]       i2c_data;
   logic              i2c_start;
   logic              i2c_done;
   logic              i2c_error;

   modport master (
      output cmd_addr, i2c_data, i2c_start,
      input  cmd_data, i2c_done, i2c_error
   );

   modport slave (
      input  cmd_addr, i2c_data, i2c_start,
      output cmd_data, i2c_done, i2c_error
   );
endinterface

// File: rtl/i2c_seq.sv
// Command sequencer: walks a table of 16-bit words into i2c_mc, retrying
// failed transfers and spacing commands by a fixed idle gap.
module i2c_seq #(
   parameter int unsigned NUM_CMDS   = 10,
   parameter int unsigned ADDR_W     = 4,
   parameter int unsigned MAX_RETRY  = 3,
   parameter int unsigned GAP_CYCLES = 500,
   parameter int unsigned TIMEOUT    = 100000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              go,
   output logic              busy,
   output logic              finished,
   output logic              failed,
   output logic [ADDR_W-1:0] fail_idx,
   i2c_seq_if.master         bus
);

   localparam int unsigned RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
   localparam int unsigned CNT_MAX = (TIMEOUT > GAP_CYCLES) ? TIMEOUT : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   // Timer expires in the WAIT cycle TIMEOUT-1 after START, so the failure
   // becomes visible exactly TIMEOUT clocks after the start pulse.
   localparam int unsigned TO_LOAD  = (TIMEOUT >= 2) ? TIMEOUT - 2 : 0;
   localparam int unsigned GAP_LOAD = (GAP_CYCLES >= 1) ? GAP_CYCLES - 1 : 0;

   localparam logic [ADDR_W-1:0]  LAST_IDX  = ADDR_W'(NUM_CMDS - 1);
   localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRY);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_START, S_WAIT, S_GAP, S_FINISH, S_FAIL
   } state_e;

   state_e               state_q, state_d;
   logic [ADDR_W-1:0]    idx_q, idx_d;
   logic [RETRY_W-1:0]   retry_q, retry_d;
   logic [CNT_W-1:0]     cnt_q, cnt_d;
   logic                 busy_q, busy_d;
   logic                 finished_q, finished_d;
   logic                 failed_q, failed_d;
   logic [ADDR_W-1:0]    fail_idx_q, fail_idx_d;
   logic [15:0]          data_q, data_d;
   logic                 start_q, start_d;

   // State and output registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q    <= S_IDLE;
         idx_q      <= '0;
         retry_q    <= '0;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         finished_q <= 1'b0;
         failed_q   <= 1'b0;
         fail_idx_q <= '0;
         data_q     <= '0;
         start_q    <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         retry_q    <= retry_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         finished_q <= finished_d;
         failed_q   <= failed_d;
         fail_idx_q <= fail_idx_d;
         data_q     <= data_d;
         start_q    <= start_d;
      end
   end

   // Next-state and registered-output logic
   always_comb begin
      state_d    = state_q;
      idx_d      = idx_q;
      retry_d    = retry_q;
      cnt_d      = cnt_q;
      busy_d     = busy_q;
      finished_d = finished_q;
      failed_d   = failed_q;
      fail_idx_d = fail_idx_q;
      data_d     = data_q;
      start_d    = 1'b0;

      case (state_q)
         S_IDLE, S_FINISH, S_FAIL: begin
            if (go) begin
               finished_d = 1'b0;
               failed_d   = 1'b0;
               idx_d      = '0;
               retry_d    = '0;
               busy_d     = 1'b1;
               state_d    = S_LOAD;
            end
         end
         S_LOAD: begin
            data_d  = bus.cmd_data;
            start_d = 1'b1;
            state_d = S_START;
         end
         S_START: begin
            cnt_d   = CNT_W'(TO_LOAD);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            // done wins over a coincident timeout
            if (bus.i2c_done && !bus.i2c_error) begin
               retry_d = '0;
               if (idx_q == LAST_IDX) begin
                  busy_d     = 1'b0;
                  finished_d = 1'b1;
                  state_d    = S_FINISH;
               end else begin
                  idx_d   = idx_q + ADDR_W'(1);
                  cnt_d   = CNT_W'(GAP_LOAD);
                  state_d = S_GAP;
               end
            end else if (bus.i2c_done || (cnt_q == '0)) begin
               if (retry_q == RETRY_MAX) begin
                  busy_d     = 1'b0;
                  failed_d   = 1'b1;
                  fail_idx_d = idx_q;
                  state_d    = S_FAIL;
               end else begin
                  retry_d = retry_q + RETRY_W'(1);
                  cnt_d   = CNT_W'(GAP_LOAD);
                  state_d = S_GAP;
               end
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         S_GAP: begin
            if (cnt_q == '0) begin
               state_d = S_LOAD;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign busy          = busy_q;
   assign finished      = finished_q;
   assign failed        = failed_q;
   assign fail_idx      = fail_idx_q;
   assign bus.cmd_addr  = idx_q;
   assign bus.i2c_data  = data_q;
   assign bus.i2c_start = start_q;

endmodule

// File: tb/tb_i2c_seq.sv
// Bench for i2c_seq: two instances (with and without retries), an i2c_mc
// responder, and an event-timing model checked against the DUT every cycle.
module tb_i2c_seq;

   localparam int NUM  = 3;
   localparam int GAP  = 20;
   localparam int TO   = 200;
   localparam int DLY  = 50;
   localparam int MAXR_A = 3;
   localparam int MAXR_B = 0;

   logic clk = 1'b0;
   logic rst;
   logic go_a, go_b;
   logic busy_a, fin_a, fail_a, busy_b, fin_b, fail_b;
   logic [3:0] fidx_a, fidx_b;

   i2c_seq_if #(.ADDR_W(4)) if_a ();
   i2c_seq_if #(.ADDR_W(4)) if_b ();

   i2c_seq #(.NUM_CMDS(NUM), .ADDR_W(4), .MAX_RETRY(MAXR_A), .GAP_CYCLES(GAP), .TIMEOUT(TO))
   dut_a (.clk(clk), .rst(rst), .go(go_a), .busy(busy_a), .finished(fin_a),
          .failed(fail_a), .fail_idx(fidx_a), .bus(if_a));

   i2c_seq #(.NUM_CMDS(NUM), .ADDR_W(4), .MAX_RETRY(MAXR_B), .GAP_CYCLES(GAP), .TIMEOUT(TO))
   dut_b (.clk(clk), .rst(rst), .go(go_b), .busy(busy_b), .finished(fin_b),
          .failed(fail_b), .fail_idx(fidx_b), .bus(if_b));

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   logic [15:0] table_w [16];
   assign if_a.cmd_data = table_w[if_a.cmd_addr];
   assign if_b.cmd_data = table_w[if_b.cmd_addr];

   // Views of both DUTs, indexed 0 = a, 1 = b
   logic        w_start [2];
   logic [15:0] w_data  [2];
   logic        w_busy  [2];
   logic        w_fin   [2];
   logic        w_fail  [2];
   logic [3:0]  w_fidx  [2];
   assign w_start[0] = if_a.i2c_start;  assign w_start[1] = if_b.i2c_start;
   assign w_data[0]  = if_a.i2c_data;   assign w_data[1]  = if_b.i2c_data;
   assign w_busy[0]  = busy_a;          assign w_busy[1]  = busy_b;
   assign w_fin[0]   = fin_a;           assign w_fin[1]   = fin_b;
   assign w_fail[0]  = fail_a;          assign w_fail[1]  = fail_b;
   assign w_fidx[0]  = fidx_a;          assign w_fidx[1]  = fidx_b;

   int n_chk = 0;
   int n_fail = 0;

   function automatic void chk(input string nm, input int k, input logic [31:0] act,
                               input logic [31:0] exp_v);
      n_chk++;
      if (act !== exp_v) begin
         n_fail++;
         $display("FAIL %s dut%0d cyc=%0d got=%0h exp=%0h", nm, k, cyc, act, exp_v);
      end
   endfunction

   // Responder script: per attempt, done after DLY clocks with the given error
   int   rsp_n   [2];
   bit   rsp_err [2][16];
   int   ptr     [2];
   bit   pend    [2];
   bit   perr    [2];
   int   pcnt    [2];
   bit   sp_mode [2];
   int   sp      [2];
   int   obs_n   [2];
   logic [15:0] obs_dat [2][32];
   bit   d_done  [2];
   bit   d_err   [2];
   assign if_a.i2c_done = d_done[0];  assign if_a.i2c_error = d_err[0];
   assign if_b.i2c_done = d_done[1];  assign if_b.i2c_error = d_err[1];

   always @(negedge clk) begin
      for (int k = 0; k < 2; k++) begin
         d_done[k] = 1'b0;
         d_err[k]  = 1'b0;
         if (!rst) begin
            pend[k] = 1'b0;
            sp[k]   = 0;
         end else begin
            if (pend[k]) begin
               pcnt[k]--;
               if (pcnt[k] == 0) begin
                  d_done[k] = 1'b1;
                  d_err[k]  = perr[k];
                  pend[k]   = 1'b0;
                  if (sp_mode[k]) sp[k] = 6;
               end
            end else if (sp[k] > 0) begin
               sp[k]--;
               if (sp[k] == 0) begin
                  d_done[k] = 1'b1;
                  d_err[k]  = 1'b1;
               end
            end
            if (w_start[k] === 1'b1) begin
               if (obs_n[k] < 32) obs_dat[k][obs_n[k]] = w_data[k];
               obs_n[k]++;
               if (ptr[k] < rsp_n[k]) begin
                  pend[k] = 1'b1;
                  pcnt[k] = DLY;
                  perr[k] = rsp_err[k][ptr[k]];
               end
               ptr[k]++;
            end
         end
      end
   end

   // Model: expected start/done cycles and final status from the command rules
   bit   armed  [2];
   int   g_go   [2];
   int   e_end  [2];
   bit   e_fin  [2];
   bit   e_fail [2];
   int   e_fidx [2];
   bit   p_fin  [2];
   bit   p_fail [2];
   int   p_fidx [2];
   int   exp_n  [2];
   int   exp_s  [2][16];
   int   exp_d  [2][16];
   logic [15:0] exp_dat [2][16];

   task automatic model_arm(input int k, input int g, input int maxr);
      int idx, retry, s, d, a;
      bit er;
      idx = 0; retry = 0; s = g + 2; a = 0;
      exp_n[k] = 0; e_fin[k] = 0; e_fail[k] = 0; e_fidx[k] = 0;
      g_go[k] = g;
      while (1) begin
         if (a < rsp_n[k]) begin
            d  = s + DLY;
            er = rsp_err[k][a];
         end else begin
            d  = s + TO - 1;
            er = 1'b1;
         end
         exp_s[k][exp_n[k]]   = s;
         exp_d[k][exp_n[k]]   = d;
         exp_dat[k][exp_n[k]] = table_w[idx];
         exp_n[k]++;
         a++;
         if (!er) begin
            if (idx == NUM - 1) begin e_end[k] = d + 1; e_fin[k] = 1; break; end
            idx++;
            retry = 0;
         end else begin
            if (retry == maxr) begin
               e_end[k] = d + 1; e_fail[k] = 1; e_fidx[k] = idx; break;
            end
            retry++;
         end
         s = d + GAP + 2;
      end
   endtask

   task automatic check_dut(input int k);
      bit xs, xb, xf, xl;
      int xi;
      xs = 0;
      if (armed[k]) begin
         for (int i = 0; i < exp_n[k]; i++) begin
            if (exp_s[k][i] == cyc) xs = 1;
            if (cyc >= exp_s[k][i] && cyc <= exp_d[k][i])
               chk("i2c_data", k, 32'(w_data[k]), 32'(exp_dat[k][i]));
         end
      end
      xb = armed[k] && cyc > g_go[k] && cyc < e_end[k];
      if (!armed[k]) begin
         xf = 0; xl = 0; xi = 0;
      end else if (cyc <= g_go[k]) begin
         xf = p_fin[k]; xl = p_fail[k]; xi = p_fidx[k];
      end else begin
         xf = e_fin[k] && cyc >= e_end[k];
         xl = e_fail[k] && cyc >= e_end[k];
         xi = e_fidx[k];
      end
      chk("i2c_start", k, 32'(w_start[k]), 32'(xs));
      chk("busy", k, 32'(w_busy[k]), 32'(xb));
      chk("finished", k, 32'(w_fin[k]), 32'(xf));
      chk("failed", k, 32'(w_fail[k]), 32'(xl));
      if (xl) chk("fail_idx", k, 32'(w_fidx[k]), 32'(xi));
   endtask

   always @(negedge clk) begin
      if (rst === 1'b1) begin
         for (int k = 0; k < 2; k++) check_dut(k);
      end
   end

   task automatic set_rsp(input int k, input int n, input logic [15:0] err_mask,
                          input bit spur);
      rsp_n[k] = n;
      for (int i = 0; i < 16; i++) rsp_err[k][i] = err_mask[i];
      ptr[k]     = 0;
      obs_n[k]   = 0;
      sp_mode[k] = spur;
   endtask

   task automatic run_go(input int k, input int maxr);
      @(negedge clk);
      if (k == 0) go_a = 1'b1; else go_b = 1'b1;
      p_fin[k]  = armed[k] && e_fin[k];
      p_fail[k] = armed[k] && e_fail[k];
      p_fidx[k] = e_fidx[k];
      model_arm(k, cyc, maxr);
      armed[k] = 1'b1;
      @(negedge clk);
      go_a = 1'b0;
      go_b = 1'b0;
   endtask

   task automatic wait_end(input int k);
      while (cyc < e_end[k] + 5) @(negedge clk);
   endtask

   task automatic chk_zero(input int k);
      chk("rst_busy", k, 32'(w_busy[k]), 32'd0);
      chk("rst_fin", k, 32'(w_fin[k]), 32'd0);
      chk("rst_fail", k, 32'(w_fail[k]), 32'd0);
      chk("rst_fidx", k, 32'(w_fidx[k]), 32'd0);
      chk("rst_start", k, 32'(w_start[k]), 32'd0);
      chk("rst_data", k, 32'(w_data[k]), 32'd0);
   endtask

   int offs [6] = '{2, 10, 60, 100, 150, 190};

   initial begin
      for (int i = 0; i < 16; i++) table_w[i] = 16'h0000;
      table_w[0] = 16'hDEAD; table_w[1] = 16'h1234; table_w[2] = 16'h0F0F;
      for (int k = 0; k < 2; k++) begin
         armed[k] = 0; e_fin[k] = 0; e_fail[k] = 0; e_fidx[k] = 0; e_end[k] = 0;
         rsp_n[k] = 0; ptr[k] = 0; obs_n[k] = 0; sp_mode[k] = 0; sp[k] = 0;
         pend[k] = 0; pcnt[k] = 0; perr[k] = 0;
      end
      rst = 1'b0; go_a = 1'b0; go_b = 1'b0;
      repeat (3) @(negedge clk);
      chk_zero(0);
      chk_zero(1);
      chk("rst_addr", 0, 32'(if_a.cmd_addr), 32'd0);
      rst = 1'b1;
      repeat (5) @(negedge clk);

      // 1: clean three-command run
      set_rsp(0, 3, 16'h0000, 1'b0);
      run_go(0, MAXR_A);
      chk("pin_s1_start0", 0, 32'(exp_s[0][0] - g_go[0]), 32'd2);
      chk("pin_s1_start1", 0, 32'(exp_s[0][1] - exp_s[0][0]), 32'(DLY + GAP + 2));
      chk("pin_s1_end", 0, 32'(e_end[0] - g_go[0]), 32'd197);
      wait_end(0);
      chk("s1_nstart", 0, 32'(obs_n[0]), 32'd3);
      chk("s1_dat0", 0, 32'(obs_dat[0][0]), 32'h0000DEAD);
      chk("s1_dat1", 0, 32'(obs_dat[0][1]), 32'h00001234);
      chk("s1_dat2", 0, 32'(obs_dat[0][2]), 32'h00000F0F);
      chk("s1_fin", 0, 32'(fin_a), 32'd1);

      // 2: command 1 errors twice then succeeds
      set_rsp(0, 5, 16'b00110, 1'b0);
      run_go(0, MAXR_A);
      chk("pin_s2_n", 0, 32'(exp_n[0]), 32'd5);
      wait_end(0);
      chk("s2_nstart", 0, 32'(obs_n[0]), 32'd5);
      chk("s2_dat3", 0, 32'(obs_dat[0][3]), 32'h00001234);
      chk("s2_dat4", 0, 32'(obs_dat[0][4]), 32'h00000F0F);
      chk("s2_fin", 0, 32'(fin_a), 32'd1);
      chk("s2_fail", 0, 32'(fail_a), 32'd0);

      // 3: command 2 fails on every attempt
      set_rsp(0, 6, 16'b111100, 1'b0);
      run_go(0, MAXR_A);
      chk("pin_s3_fidx", 0, 32'(e_fidx[0]), 32'd2);
      wait_end(0);
      chk("s3_nstart", 0, 32'(obs_n[0]), 32'd6);
      chk("s3_dat5", 0, 32'(obs_dat[0][5]), 32'h00000F0F);
      chk("s3_fail", 0, 32'(fail_a), 32'd1);
      chk("s3_fidx", 0, 32'(fidx_a), 32'd2);
      chk("s3_fin", 0, 32'(fin_a), 32'd0);
      chk("s3_busy", 0, 32'(busy_a), 32'd0);

      // 4: no done ever, no retries
      set_rsp(1, 0, 16'h0000, 1'b0);
      run_go(1, MAXR_B);
      chk("pin_s4_end", 1, 32'(e_end[1] - exp_s[1][0]), 32'd200);
      while (cyc < exp_s[1][0] + 199) @(negedge clk);
      chk("s4_fail_early", 1, 32'(fail_b), 32'd0);
      @(negedge clk);
      chk("s4_fail_at200", 1, 32'(fail_b), 32'd1);
      wait_end(1);
      chk("s4_nstart", 1, 32'(obs_n[1]), 32'd1);
      chk("s4_fidx", 1, 32'(fidx_b), 32'd0);
      set_rsp(1, 3, 16'h0000, 1'b0);
      run_go(1, MAXR_B);
      chk("s4b_fail_clr", 1, 32'(fail_b), 32'd0);
      wait_end(1);
      chk("s4b_dat0", 1, 32'(obs_dat[1][0]), 32'h0000DEAD);
      chk("s4b_fin", 1, 32'(fin_b), 32'd1);

      // 5: go pulses while busy and spurious done in the gap
      set_rsp(0, 3, 16'h0000, 1'b1);
      run_go(0, MAXR_A);
      for (int i = 0; i < 6; i++) begin
         while (cyc < g_go[0] + offs[i]) @(negedge clk);
         go_a = 1'b1;
         @(negedge clk);
         go_a = 1'b0;
      end
      wait_end(0);
      chk("s5_nstart", 0, 32'(obs_n[0]), 32'd3);
      chk("s5_fin", 0, 32'(fin_a), 32'd1);
      sp_mode[0] = 1'b0;
      repeat (10) @(negedge clk);

      // 6: reset in WAIT of command 1
      set_rsp(0, 3, 16'h0000, 1'b0);
      run_go(0, MAXR_A);
      while (cyc < exp_s[0][1] + 10) @(negedge clk);
      #2;
      rst = 1'b0;
      armed[0] = 1'b0;
      armed[1] = 1'b0;
      #1;
      chk_zero(0);
      chk_zero(1);
      chk("rst6_addr", 0, 32'(if_a.cmd_addr), 32'd0);
      repeat (3) @(negedge clk);
      rst = 1'b1;
      repeat (30) @(negedge clk);
      chk("s6_idle_nstart", 0, 32'(obs_n[0]), 32'd2);
      set_rsp(0, 3, 16'h0000, 1'b0);
      run_go(0, MAXR_A);
      wait_end(0);
      chk("s6_dat0", 0, 32'(obs_dat[0][0]), 32'h0000DEAD);
      chk("s6_nstart", 0, 32'(obs_n[0]), 32'd3);
      chk("s6_fin", 0, 32'(fin_a), 32'd1);

      $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog cyc=%0d got=timeout exp=finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule
